// File: rtl/uart_framer_pkg.sv
// Shared types and helpers for the UART sample framer.
package uart_framer_pkg;

    // Framer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Bytes per frame: sync, seq, sample high, sample low, checksum
    localparam int C_FRAME_LEN = 5;

    // Frame checksum: XOR of the sequence byte and both sample bytes
    function automatic logic [7:0] frame_checksum(input logic [7:0] seq_b,
                                                  input logic [15:0] smp);
        return seq_b ^ smp[15:8] ^ smp[7:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Read data is the head entry, valid in the same cycle
// as the pop. Pointers carry one extra wrap bit so full and empty differ.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_rd;
    logic         do_wr;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_rd   = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a write into a full FIFO succeeds
    assign do_wr   = wr_en && (!full || do_rd);

    // Pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_sample_framer.sv
// Buffers ADC samples and emits each as a 5-byte frame
// (sync, seq, S[15:8], S[7:0], checksum) over the tx data/send/busy handshake.
// Handshake: tx_send rises with tx_data stable and stays high until tx_busy
// is seen high; the framer then waits for tx_busy low before the next byte.
module uart_sample_framer
    import uart_framer_pkg::*;
#(
    parameter int         C_SAMPLE_WIDTH = 16,
    parameter int         C_FIFO_DEPTH   = 8,
    parameter logic [7:0] C_SYNC_BYTE    = 8'hA5,
    parameter int         C_ACK_TIMEOUT  = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [C_SAMPLE_WIDTH-1:0] sample_data,
    input  logic                      sample_valid,
    input  logic                      clear,
    output logic [7:0]                tx_data,
    output logic                      tx_send,
    input  logic                      tx_busy,
    input  logic                      tx_error,
    output logic                      frame_active,
    output logic                      overflow,
    output logic [7:0]                drop_count,
    output logic                      err_timeout,
    output logic [7:0]                seq,
    output logic [1:0]                dbg_state
);
    localparam int         TW   = $clog2(C_ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(C_ACK_TIMEOUT - 1);

    state_t        state_q;
    logic [2:0]    idx_q;
    logic [15:0]   smp_q;
    logic [7:0]    seq_q;
    logic [7:0]    tx_data_q;
    logic [7:0]    tx_data_d;
    logic          tx_send_q;
    logic          frame_active_q;
    logic          err_q;
    logic          overflow_q;
    logic [7:0]    drop_count_q;
    logic [TW-1:0] timer_q;

    logic [15:0]   sample_ext;
    logic [15:0]   fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          drop;

    assign sample_ext = 16'($signed(sample_data));
    assign pop        = (state_q == IDLE) && !fifo_empty && !tx_error;
    assign drop       = sample_valid && fifo_full && !pop;

    sync_fifo #(
        .W     (16),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (sample_valid),
        .wr_data (sample_ext),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Select the frame byte for the current index
    always_comb begin
        tx_data_d = C_SYNC_BYTE;
        case (idx_q)
            3'd0:    tx_data_d = C_SYNC_BYTE;
            3'd1:    tx_data_d = seq_q;
            3'd2:    tx_data_d = smp_q[15:8];
            3'd3:    tx_data_d = smp_q[7:0];
            default: tx_data_d = frame_checksum(seq_q, smp_q);
        endcase
    end

    // Framer FSM with registered handshake outputs; tx_error aborts from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            smp_q          <= '0;
            seq_q          <= '0;
            tx_data_q      <= '0;
            tx_send_q      <= 1'b0;
            frame_active_q <= 1'b0;
            err_q          <= 1'b0;
            timer_q        <= '0;
        end else begin
            if (clear) err_q <= 1'b0;
            if (tx_error) begin
                err_q          <= 1'b1;
                tx_send_q      <= 1'b0;
                frame_active_q <= 1'b0;
                state_q        <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!fifo_empty) begin
                            smp_q          <= fifo_rd_data;
                            idx_q          <= '0;
                            frame_active_q <= 1'b1;
                            state_q        <= LOAD;
                        end
                    end
                    LOAD: begin
                        tx_data_q <= tx_data_d;
                        timer_q   <= '0;
                        state_q   <= REQ;
                    end
                    REQ: begin
                        // Busy only counts as an ack once our request is visible
                        if (!tx_send_q) begin
                            tx_send_q <= 1'b1;
                        end else if (tx_busy) begin
                            tx_send_q <= 1'b0;
                            state_q   <= DRAIN;
                        end else if (timer_q == TMAX) begin
                            err_q          <= 1'b1;
                            tx_send_q      <= 1'b0;
                            frame_active_q <= 1'b0;
                            state_q        <= IDLE;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (!tx_busy) begin
                            if (idx_q == 3'(C_FRAME_LEN - 1)) begin
                                seq_q          <= seq_q + 8'd1;
                                frame_active_q <= 1'b0;
                                state_q        <= IDLE;
                            end else begin
                                idx_q   <= idx_q + 3'd1;
                                state_q <= LOAD;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (clear) begin
                overflow_q   <= 1'b0;
                drop_count_q <= '0;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (clear)
                    drop_count_q <= 8'd1;
                else if (drop_count_q != 8'hFF)
                    drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_send      = tx_send_q;
    assign frame_active = frame_active_q;
    assign overflow     = overflow_q;
    assign drop_count   = drop_count_q;
    assign err_timeout  = err_q;
    assign seq          = seq_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_sample_framer.sv
// Directed bench for uart_sample_framer: a 16-bit and a 12-bit instance,
// each with a simple transmitter model that acks and stays busy a few cycles.
module tb_uart_sample_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        tx_error = 1'b0;

    // 16-bit instance
    logic [15:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy = 1'b0;
    logic        frame_active;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        err_timeout;
    logic [7:0]  seq;
    logic [1:0]  dbg_state;

    // 12-bit instance
    logic [11:0] sample_data2 = '0;
    logic        sample_valid2 = 1'b0;
    logic [7:0]  tx_data2;
    logic        tx_send2;
    logic        tx_busy2 = 1'b0;
    logic        frame_active2;
    logic        overflow2;
    logic [7:0]  drop_count2;
    logic        err_timeout2;
    logic [7:0]  seq2;
    logic [1:0]  dbg_state2;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          ack_en = 1'b1;
    int          busy_cnt = 0;
    int          busy2_cnt = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  got2_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_seq;
    logic [7:0]  exp12 [10] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h22,
                                8'hA5, 8'h01, 8'hF8, 8'h00, 8'hF9};

    always #5 clk = ~clk;

    uart_sample_framer dut (
        .clk(clk), .rst(rst), .sample_data(sample_data), .sample_valid(sample_valid),
        .clear(clear), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .tx_error(tx_error), .frame_active(frame_active), .overflow(overflow),
        .drop_count(drop_count), .err_timeout(err_timeout), .seq(seq), .dbg_state(dbg_state)
    );

    uart_sample_framer #(.C_SAMPLE_WIDTH(12)) dut12 (
        .clk(clk), .rst(rst), .sample_data(sample_data2), .sample_valid(sample_valid2),
        .clear(clear), .tx_data(tx_data2), .tx_send(tx_send2), .tx_busy(tx_busy2),
        .tx_error(1'b0), .frame_active(frame_active2), .overflow(overflow2),
        .drop_count(drop_count2), .err_timeout(err_timeout2), .seq(seq2), .dbg_state(dbg_state2)
    );

    // Transmitter model for the 16-bit instance; ack can be withheld
    always @(negedge clk) begin
        if (rst) begin
            tx_busy  = 1'b0;
            busy_cnt = 0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end else if (ack_en && tx_send && !tx_busy) begin
            got_q.push_back(tx_data);
            tx_busy  = 1'b1;
            busy_cnt = 3;
        end
    end

    // Transmitter model for the 12-bit instance; always acks
    always @(negedge clk) begin
        if (rst) begin
            tx_busy2  = 1'b0;
            busy2_cnt = 0;
        end else if (busy2_cnt > 0) begin
            busy2_cnt--;
            if (busy2_cnt == 0) tx_busy2 = 1'b0;
        end else if (tx_send2 && !tx_busy2) begin
            got2_q.push_back(tx_data2);
            tx_busy2  = 1'b1;
            busy2_cnt = 2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push16(input logic [15:0] v);
        sample_data  = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] s, input logic [15:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back(s);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(s ^ d[15:8] ^ d[7:0]);
    endtask

    task automatic drain_check(input string tag);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (frame_active !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        tick(2);
        check({tag, "_idle"}, frame_active, 1'b0);
    endtask

    initial begin
        int cnt;
        int t;
        logic [15:0] d;

        // Reset state
        tick(3);
        check("rst_tx_send", tx_send, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_frame_active", frame_active, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drop_count", drop_count, 8'h00);
        check("rst_err", err_timeout, 1'b0);
        check("rst_seq", seq, 8'h00);
        check("rst_state", dbg_state, 2'd0);
        rst = 1'b0;
        tick(2);

        // 1: single sample 0x1234 -> A5 00 12 34 26
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h12);
        exp_q.push_back(8'h34); exp_q.push_back(8'h26);
        push16(16'h1234);
        drain_check("t1_byte");
        wait_idle("t1");
        check("t1_seq", seq, 8'h01);
        check("t1_overflow", overflow, 1'b0);
        check("t1_err", err_timeout, 1'b0);

        // 2: 12-bit instance, 0x123 (seq 0) then 0x800 sign-extends to 0xF800 (seq 1)
        sample_data2 = 12'h123; sample_valid2 = 1'b1; @(negedge clk);
        sample_data2 = 12'h800; @(negedge clk);
        sample_valid2 = 1'b0;
        t = 0;
        while (got2_q.size() < 10 && t < 2000) begin @(negedge clk); t++; end
        check("t2_count", got2_q.size(), 10);
        for (int i = 0; i < 10 && got2_q.size() > 0; i++)
            check("t2_byte", got2_q.pop_front(), exp12[i]);
        tick(6);
        check("t2_seq", seq2, 8'h02);

        // 3: one frame stalled in REQ, ten samples in ten cycles -> two dropped
        ack_en = 1'b0;
        push16(16'hBEEF);
        t = 0;
        while (tx_send !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("t3_stall_req", tx_send, 1'b1);
        for (int i = 0; i < 10; i++) begin
            sample_data  = 16'h0100 + 16'(i);
            sample_valid = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check("t3_overflow", overflow, 1'b1);
        check("t3_drop_count", drop_count, 8'd2);
        // Drop and clear in the same cycle: the drop wins, count restarts at 1
        sample_data = 16'hDEAD; sample_valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0; clear = 1'b0;
        check("t3_clr_evt_overflow", overflow, 1'b1);
        check("t3_clr_evt_drop_count", drop_count, 8'd1);
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        check("t3_clear_overflow", overflow, 1'b0);
        check("t3_clear_drop_count", drop_count, 8'd0);
        exp_seq = 8'd1;
        expect_frame(exp_seq, 16'hBEEF);
        for (int i = 0; i < 8; i++) expect_frame(exp_seq + 8'(i + 1), 16'h0100 + 16'(i));
        ack_en = 1'b1;
        drain_check("t3_byte");
        wait_idle("t3");
        check("t3_seq", seq, 8'd10);
        check("t3_err", err_timeout, 1'b0);

        // 4: latency, then handshake timeout with no ack
        ack_en = 1'b0;
        push16(16'h00FF);
        check("t4_lat_n0_send", tx_send, 1'b0);
        tick(1);
        check("t4_lat_n1_active", frame_active, 1'b1);
        check("t4_lat_n1_send", tx_send, 1'b0);
        tick(1);
        check("t4_lat_n2_send", tx_send, 1'b0);
        check("t4_lat_n2_data", tx_data, 8'hA5);
        tick(1);
        check("t4_lat_n3_send", tx_send, 1'b1);
        check("t4_lat_n3_data", tx_data, 8'hA5);
        cnt = 0;
        while (tx_send === 1'b1 && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check("t4_send_cycles", cnt, 1024);
        check("t4_err", err_timeout, 1'b1);
        check("t4_active", frame_active, 1'b0);
        check("t4_seq", seq, 8'd10);
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        check("t4_err_cleared", err_timeout, 1'b0);
        ack_en = 1'b1;
        expect_frame(8'd10, 16'hFF80);
        push16(16'hFF80);
        drain_check("t4_byte");
        wait_idle("t4");
        check("t4_seq_after", seq, 8'd11);

        // tx_error mid-frame aborts without advancing seq
        push16(16'h4242);
        t = 0;
        while (got_q.size() < 2 && t < 200) begin @(negedge clk); t++; end
        tx_error = 1'b1; @(negedge clk); tx_error = 1'b0;
        check("terr_active", frame_active, 1'b0);
        check("terr_send", tx_send, 1'b0);
        check("terr_err", err_timeout, 1'b1);
        check("terr_seq", seq, 8'd11);
        tick(6);
        got_q.delete();
        clear = 1'b1; @(negedge clk); clear = 1'b0;

        // 5: reset during B2 with more samples queued
        push16(16'h7777);
        push16(16'h1357);
        push16(16'h2468);
        t = 0;
        while (got_q.size() < 3 && t < 200) begin @(negedge clk); t++; end
        check("t5_reached_b2", got_q.size(), 3);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("t5_send", tx_send, 1'b0);
        check("t5_active", frame_active, 1'b0);
        check("t5_seq", seq, 8'd0);
        check("t5_err", err_timeout, 1'b0);
        tick(8);
        check("t5_fifo_empty_active", frame_active, 1'b0);
        check("t5_fifo_empty_send", tx_send, 1'b0);
        got_q.delete();

        // 6: 257 frames, seq wraps 0xFF -> 0x00
        exp_seq = 8'd0;
        for (int i = 0; i < 257; i++) begin
            d = (16'(i) * 16'h0101) ^ 16'h5A3C;
            expect_frame(exp_seq, d);
            push16(d);
            drain_check("t6_byte");
            exp_seq = exp_seq + 8'd1;
        end
        wait_idle("t6");
        check("t6_seq_wrapped", seq, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
